// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus layout, stall patterns and
// multi-cycle sequencer state encodings.
package pipe_ctrl_pkg;

  localparam int StallBusW     = 6;
  localparam int McLenWDefault = 6;

  typedef logic [StallBusW-1:0] stall_bus_t;

  // bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM, bit5 WB
  localparam stall_bus_t NoStall     = 6'b000000;
  localparam stall_bus_t StallFromId = 6'b000111;
  localparam stall_bus_t StallFromEx = 6'b001111;

  typedef enum logic [1:0] {
    McIdle = 2'b00,
    McRun  = 2'b01,
    McDone = 2'b10
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Stall merge for ID/EX hazards plus a sequencer that holds the front of the
// pipeline while a multi-cycle EX operation runs, then releases it exactly once.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = McLenWDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                mc_start,
  input  logic [MC_LEN_W-1:0] mc_len,
  input  logic                flush,
  output logic [5:0]          stall,
  output logic                mc_done,
  output logic                mc_abort,
  output logic                busy
);

  localparam logic [MC_LEN_W-1:0] LenZero = {MC_LEN_W{1'b0}};
  localparam logic [MC_LEN_W-1:0] LenOne  = {{(MC_LEN_W-1){1'b0}}, 1'b1};

  mc_state_e           state_r;
  mc_state_e           state_nxt_s;
  logic [MC_LEN_W-1:0] cnt_r;
  logic [MC_LEN_W-1:0] cnt_nxt_s;
  logic                mc_hold_s;
  logic                done_s;
  logic                abort_s;
  stall_bus_t          stall_s;

  // Sequencer state and remaining-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= McIdle;
      cnt_r   <= LenZero;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; flush overrides everything, including a coincident start
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mc_hold_s   = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    if (flush) begin
      state_nxt_s = McIdle;
      cnt_nxt_s   = LenZero;
      abort_s     = (state_r != McIdle);
    end else begin
      case (state_r)
        McIdle: begin
          if (mc_start) begin
            mc_hold_s = 1'b1;
            if (mc_len <= LenOne) begin
              state_nxt_s = McDone;
            end else begin
              state_nxt_s = McRun;
              cnt_nxt_s   = mc_len - LenOne;
            end
          end else begin
            state_nxt_s = McIdle;
          end
        end
        McRun: begin
          mc_hold_s = 1'b1;
          cnt_nxt_s = cnt_r - LenOne;
          // <= rather than == so a corrupted zero count cannot wrap into a long hold
          if (cnt_r <= LenOne) begin
            state_nxt_s = McDone;
          end else begin
            state_nxt_s = McRun;
          end
        end
        McDone: begin
          done_s      = 1'b1;
          state_nxt_s = McIdle;
        end
        default: begin
          state_nxt_s = McIdle;
          cnt_nxt_s   = LenZero;
        end
      endcase
    end
  end

  // Merge all stall sources into one hold vector
  always_comb begin
    stall_s = NoStall;
    if (flush) begin
      stall_s = NoStall;
    end else begin
      if (mc_hold_s || stallreq_ex) begin
        stall_s = stall_s | StallFromEx;
      end else begin
        stall_s = stall_s | NoStall;
      end
      if (stallreq_id) begin
        stall_s = stall_s | StallFromId;
      end else begin
        stall_s = stall_s | NoStall;
      end
    end
  end

  // Outputs are held quiet for the whole reset window, whatever the inputs do
  always_comb begin
    if (rst) begin
      stall    = NoStall;
      mc_done  = 1'b0;
      mc_abort = 1'b0;
      busy     = 1'b0;
    end else begin
      stall    = stall_s;
      mc_done  = done_s;
      mc_abort = abort_s;
      busy     = (state_r != McIdle);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected outputs,
// which are popped and compared against the DUT later in the same cycle.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id;
  logic       stallreq_ex;
  logic       mc_start;
  logic [5:0] mc_len;
  logic       flush;
  logic [5:0] stall;
  logic       mc_done;
  logic       mc_abort;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [5:0] stall;
    logic       done;
    logic       abort;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  pipe_ctrl #(.MC_LEN_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .mc_start    (mc_start),
    .mc_len      (mc_len),
    .flush       (flush),
    .stall       (stall),
    .mc_done     (mc_done),
    .mc_abort    (mc_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare mid-cycle.
  task automatic step(input logic r, input logic id, input logic ex, input logic st,
                      input logic [5:0] len, input logic fl,
                      input logic [5:0] es, input logic ed, input logic ea, input logic eb,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst         = r;
    stallreq_id = id;
    stallreq_ex = ex;
    mc_start    = st;
    mc_len      = len;
    flush       = fl;
    e.stall = es;
    e.done  = ed;
    e.abort = ea;
    e.busy  = eb;
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".stall"}, {10'd0, stall}, {10'd0, e.stall});
      check_val({tag, ".done"},  {15'd0, mc_done}, {15'd0, e.done});
      check_val({tag, ".abort"}, {15'd0, mc_abort}, {15'd0, e.abort});
      check_val({tag, ".busy"},  {15'd0, busy}, {15'd0, e.busy});
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // A complete multi-cycle op: N hold cycles, done in cycle N, then idle.
  task automatic run_op(input logic [5:0] len, input string tag);
    int n;
    n = (len == 6'd0) ? 1 : int'(len);
    step(1'b0, 1'b0, 1'b0, 1'b1, len, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, {tag, ".start"});
    for (int i = 1; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, {tag, ".run"});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, {tag, ".done"});
    idle({tag, ".after"});
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    mc_start = 1'b0; mc_len = 6'd0; flush = 1'b0;

    // Reset masks every input
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, "rst_hold");
    end
    idle("rst_release");
    idle("rst_idle");

    // Plain stall requests
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'h07, 1'b0, 1'b0, 1'b0, "req_id");
    step(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "req_ex");
    step(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "req_both");
    step(1'b0, 1'b1, 1'b1, 1'b1, 6'd4, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, "flush_masks");
    idle("req_clear");

    run_op(6'd5, "op5");
    run_op(6'd0, "op0");
    run_op(6'd1, "op1");
    run_op(6'd2, "op2");
    run_op(6'd63, "op63");

    // Second start during an op is ignored; start right after done is taken
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "b2b.t0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "b2b.t1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "b2b.t2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "b2b.t3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "b2b.t4");
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, "b2b.t5");
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "b2b.t6");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, "b2b.t7");
    idle("b2b.t8");

    // Flush at T+3 of an 8-cycle op
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "fl.t0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "fl.t1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "fl.t2");
    step(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 6'h00, 1'b0, 1'b1, 1'b1, "fl.t3");
    for (int i = 0; i < 8; i++) idle("fl.post");

    // Flush with a coincident start in IDLE discards the start
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, "flst.t0");
    idle("flst.t1");

    // Flush landing on the DONE cycle suppresses mc_done
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "fldn.t0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'h00, 1'b0, 1'b1, 1'b1, "fldn.t1");
    idle("fldn.t2");

    // ID hazard during DONE only freezes PC..ID
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "iddn.t0");
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "iddn.t1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'h07, 1'b1, 1'b0, 1'b1, "iddn.t2");
    idle("iddn.t3");

    // Reset mid-op kills it without a done pulse
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b0, "rstop.t0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h0F, 1'b0, 1'b0, 1'b1, "rstop.t1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, "rstop.t2");
    for (int i = 0; i < 6; i++) idle("rstop.post");

    if (sb_q.size() != 0) check_val("sb_drain", 16'(sb_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
